// File: rtl/dds_tuning_ctrl_if.sv
// Front-panel tuning bus: raw buttons, start pulse and coarse table in; LEDs and tuning word out.
interface dds_tuning_ctrl_if #(
   parameter int unsigned INC_WIDTH  = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned FINE_STEPS = 8
);
   localparam int unsigned CW = $clog2(DEPTH);
   localparam int unsigned FW = $clog2(FINE_STEPS);

   logic                               i_start;
   logic                               i_aumentar;
   logic                               i_disminuir;
   logic                               i_tipo_ajuste;
   logic [DEPTH-1:0][INC_WIDTH-1:0]    i_rom_incremento_grueso;
   logic [CW-1:0]                      o_leds_grueso;
   logic [FW-1:0]                      o_leds_fino;
   logic                               o_sweeping;
   logic [INC_WIDTH-1:0]               o_incremento;
   logic                               o_inc_valid;

   modport master (
      output i_start, i_aumentar, i_disminuir, i_tipo_ajuste, i_rom_incremento_grueso,
      input  o_leds_grueso, o_leds_fino, o_sweeping, o_incremento, o_inc_valid
   );

   modport slave (
      input  i_start, i_aumentar, i_disminuir, i_tipo_ajuste, i_rom_incremento_grueso,
      output o_leds_grueso, o_leds_fino, o_sweeping, o_incremento, o_inc_valid
   );
endinterface

// File: rtl/dds_tuning_ctrl.sv
// DDS tuning controller: synchronised, debounced up/down buttons with hold-to-repeat,
// coarse/fine index stepping, automatic coarse sweep, saturating registered tuning word.
module dds_tuning_ctrl #(
   parameter int unsigned          INC_WIDTH       = 32,
   parameter int unsigned          DEPTH           = 16,
   parameter int unsigned          FINE_STEPS      = 8,
   parameter logic [INC_WIDTH-1:0] FINE_STEP       = INC_WIDTH'(32'h0000_0100),
   parameter int unsigned          DEBOUNCE_CYCLES = 1000,
   parameter int unsigned          HOLD_CYCLES     = 50_000_000,
   parameter int unsigned          REPEAT_CYCLES   = 12_500_000,
   parameter int unsigned          SWEEP_DWELL     = 125_000_000
) (
   input logic              i_clk,
   input logic              i_rst,
   input logic              i_enable,
   dds_tuning_ctrl_if.slave bus
);
   localparam int unsigned CW   = $clog2(DEPTH);
   localparam int unsigned FW   = $clog2(FINE_STEPS);
   localparam int unsigned SW   = INC_WIDTH + FW + 1;
   localparam int unsigned DBW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned RW   = $clog2(RMAX + 1);
   localparam int unsigned DWW  = $clog2(SWEEP_DWELL + 1);

   typedef enum logic {S_IDLE, S_SWEEP} state_t;

   // bit 0 = up, bit 1 = down, bit 2 = mode select
   logic [2:0]           sync1_q, sync2_q;
   logic                 mode_q;
   logic [DBW-1:0]       deb_cnt_q [2];
   logic [DBW-1:0]       deb_cnt_d [2];
   logic [RW-1:0]        rpt_q [2];
   logic [RW-1:0]        rpt_d [2];
   logic [1:0]           first_q, first_d, phase_q, phase_d, ev_q, ev_d, deb_c;
   logic                 both_c, mode_chg_c;

   state_t               state_q, state_d;
   logic [CW-1:0]        coarse_q, coarse_d;
   logic [FW-1:0]        fine_q, fine_d;
   logic [DWW-1:0]       dwell_q, dwell_d;
   logic [SW-1:0]        sum_c;
   logic [INC_WIDTH-1:0] inc_q, inc_d;
   logic                 valid_q, valid_d;

   assign deb_c      = {deb_cnt_q[1] == DBW'(DEBOUNCE_CYCLES), deb_cnt_q[0] == DBW'(DEBOUNCE_CYCLES)};
   assign both_c     = &deb_c;
   assign mode_chg_c = sync2_q[2] ^ mode_q;

   // Debounce counters and hold/repeat timers; the first event fires when the count reaches the threshold
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         deb_cnt_d[b] = deb_cnt_q[b];
         rpt_d[b]     = rpt_q[b];
         first_d[b]   = first_q[b];
         phase_d[b]   = phase_q[b];
         ev_d[b]      = 1'b0;
         if (!sync2_q[b]) begin
            deb_cnt_d[b] = '0;
         end else if (!deb_c[b]) begin
            deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
         end
         if (!deb_c[b]) begin
            first_d[b] = 1'b0;
            rpt_d[b]   = '0;
            phase_d[b] = 1'b0;
         end else if (both_c) begin
            // a chord consumes the first event; the survivor only resumes repeating
            first_d[b] = 1'b1;
            rpt_d[b]   = '0;
            phase_d[b] = 1'b0;
         end else if (!first_q[b]) begin
            ev_d[b]    = 1'b1;
            first_d[b] = 1'b1;
            rpt_d[b]   = '0;
            phase_d[b] = 1'b0;
         end else if (mode_chg_c) begin
            rpt_d[b]   = '0;
            phase_d[b] = 1'b0;
         end else if (rpt_q[b] == (phase_q[b] ? RW'(REPEAT_CYCLES - 1) : RW'(HOLD_CYCLES - 1))) begin
            ev_d[b]    = 1'b1;
            rpt_d[b]   = '0;
            phase_d[b] = 1'b1;
         end else begin
            rpt_d[b]   = rpt_q[b] + 1'b1;
         end
      end
   end

   // Input synchronisers and button front-end state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         mode_q  <= 1'b0;
         first_q <= '0;
         phase_q <= '0;
         ev_q    <= '0;
         for (int b = 0; b < 2; b++) begin
            deb_cnt_q[b] <= '0;
            rpt_q[b]     <= '0;
         end
      end else if (i_enable) begin
         sync1_q <= {bus.i_tipo_ajuste, bus.i_disminuir, bus.i_aumentar};
         sync2_q <= sync1_q;
         mode_q  <= sync2_q[2];
         first_q <= first_d;
         phase_q <= phase_d;
         ev_q    <= ev_d;
         for (int b = 0; b < 2; b++) begin
            deb_cnt_q[b] <= deb_cnt_d[b];
            rpt_q[b]     <= rpt_d[b];
         end
      end
   end

   // Mode FSM, index stepping/sweep and saturating tuning-word computation
   always_comb begin
      state_d  = state_q;
      coarse_d = coarse_q;
      fine_d   = fine_q;
      dwell_d  = dwell_q;
      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               state_d  = S_SWEEP;
               coarse_d = '0;
               dwell_d  = '0;
            end else if (ev_q[0]) begin
               if (sync2_q[2]) begin
                  if (fine_q != FW'(FINE_STEPS - 1)) fine_d = fine_q + 1'b1;
               end else if (coarse_q != CW'(DEPTH - 1)) begin
                  coarse_d = coarse_q + 1'b1;
               end
            end else if (ev_q[1]) begin
               if (sync2_q[2]) begin
                  if (fine_q != '0) fine_d = fine_q - 1'b1;
               end else if (coarse_q != '0) begin
                  coarse_d = coarse_q - 1'b1;
               end
            end
         end
         S_SWEEP: begin
            if (bus.i_start) begin
               state_d = S_IDLE;
            end else if (dwell_q == DWW'(SWEEP_DWELL - 1)) begin
               dwell_d  = '0;
               coarse_d = (coarse_q == CW'(DEPTH - 1)) ? '0 : coarse_q + 1'b1;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      sum_c   = SW'(bus.i_rom_incremento_grueso[coarse_q]) + SW'(fine_q) * SW'(FINE_STEP);
      inc_d   = (|sum_c[SW-1:INC_WIDTH]) ? '1 : sum_c[INC_WIDTH-1:0];
      valid_d = (inc_d != inc_q);
   end

   // Controller state and output registers; enable low freezes everything and silences valid
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         coarse_q <= '0;
         fine_q   <= '0;
         dwell_q  <= '0;
         inc_q    <= '0;
         valid_q  <= 1'b0;
      end else if (i_enable) begin
         state_q  <= state_d;
         coarse_q <= coarse_d;
         fine_q   <= fine_d;
         dwell_q  <= dwell_d;
         inc_q    <= inc_d;
         valid_q  <= valid_d;
      end else begin
         valid_q  <= 1'b0;
      end
   end

   assign bus.o_leds_grueso = coarse_q;
   assign bus.o_leds_fino   = fine_q;
   assign bus.o_sweeping    = (state_q == S_SWEEP);
   assign bus.o_incremento  = inc_q;
   assign bus.o_inc_valid   = valid_q;

endmodule

// File: tb/tb_dds_tuning_ctrl.sv
// Self-checking bench for dds_tuning_ctrl with a press-duration level reference model.
module tb_dds_tuning_ctrl;
   localparam int unsigned INC_WIDTH  = 32;
   localparam int unsigned DEPTH      = 16;
   localparam int unsigned FINE_STEPS = 8;
   localparam int unsigned DEB        = 4;
   localparam int unsigned HOLD       = 20;
   localparam int unsigned REP        = 5;
   localparam int unsigned DWELL      = 8;

   logic        clk, rst, en;
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned vcount = 0;
   logic [31:0] tbl [DEPTH];
   int unsigned coarse_m, fine_m;
   logic        mode_m;

   dds_tuning_ctrl_if #(.INC_WIDTH(INC_WIDTH), .DEPTH(DEPTH), .FINE_STEPS(FINE_STEPS)) bus ();

   dds_tuning_ctrl #(
      .INC_WIDTH(INC_WIDTH), .DEPTH(DEPTH), .FINE_STEPS(FINE_STEPS), .FINE_STEP(32'h0000_0100),
      .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .SWEEP_DWELL(DWELL)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_enable(en), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus.o_inc_valid === 1'b1) vcount++;

   // Expected word: table entry plus fine offset, clamped to all-ones
   function automatic logic [31:0] word_m(input int unsigned c, input int unsigned f);
      logic [63:0] s;
      s = 64'(tbl[c]) + 64'(f) * 64'h100;
      if (s > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
      return s[31:0];
   endfunction

   // Number of events produced by a lone button held for len sampled cycles
   function automatic int unsigned n_events(input int unsigned len);
      if (len < DEB) return 0;
      if (len - DEB < HOLD) return 1;
      return 2 + (len - DEB - HOLD) / REP;
   endfunction

   task automatic tick(input int unsigned n = 1);
      for (int i = 0; i < int'(n); i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_mode(input logic m);
      bus.i_tipo_ajuste = m;
      tick(4);
      mode_m = m;
   endtask

   task automatic step_model(input int btn);
      if (mode_m) begin
         if (btn == 0 && fine_m < FINE_STEPS - 1) fine_m++;
         else if (btn == 1 && fine_m > 0) fine_m--;
      end else begin
         if (btn == 0 && coarse_m < DEPTH - 1) coarse_m++;
         else if (btn == 1 && coarse_m > 0) coarse_m--;
      end
   endtask

   // btn: 0 = up, 1 = down, 2 = both
   task automatic do_press(input int btn, input int unsigned len, input string name);
      int unsigned v0, n, pulses;
      logic [31:0] w, nw;
      n      = (btn == 2) ? 0 : n_events(len);
      w      = word_m(coarse_m, fine_m);
      pulses = 0;
      for (int i = 0; i < int'(n); i++) begin
         step_model(btn);
         nw = word_m(coarse_m, fine_m);
         if (nw != w) pulses++;
         w = nw;
      end
      v0 = vcount;
      bus.i_aumentar  = (btn != 1);
      bus.i_disminuir = (btn != 0);
      tick(len);
      bus.i_aumentar  = 1'b0;
      bus.i_disminuir = 1'b0;
      tick(12);
      checks++;
      if (bus.o_leds_grueso !== 4'(coarse_m)) begin
         errors++;
         $display("FAIL %s coarse: got %0d expected %0d", name, bus.o_leds_grueso, coarse_m);
      end
      checks++;
      if (bus.o_leds_fino !== 3'(fine_m)) begin
         errors++;
         $display("FAIL %s fine: got %0d expected %0d", name, bus.o_leds_fino, fine_m);
      end
      checks++;
      if (bus.o_incremento !== w) begin
         errors++;
         $display("FAIL %s word: got %h expected %h", name, bus.o_incremento, w);
      end
      checks++;
      if (vcount - v0 != pulses) begin
         errors++;
         $display("FAIL %s valid pulses: got %0d expected %0d", name, vcount - v0, pulses);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(3);
      checks++;
      if (bus.o_leds_grueso !== 4'd0 || bus.o_leds_fino !== 3'd0 || bus.o_sweeping !== 1'b0) begin
         errors++;
         $display("FAIL reset leds/sweep: got %0d %0d %b expected 0 0 0",
                  bus.o_leds_grueso, bus.o_leds_fino, bus.o_sweeping);
      end
      checks++;
      if (bus.o_incremento !== 32'd0 || bus.o_inc_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset word/valid: got %h %b expected 0 0", bus.o_incremento, bus.o_inc_valid);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.o_incremento !== 32'h0000_8638 || bus.o_inc_valid !== 1'b1) begin
         errors++;
         $display("FAIL first load: got %h %b expected 00008638 1", bus.o_incremento, bus.o_inc_valid);
      end
      tick();
      checks++;
      if (bus.o_inc_valid !== 1'b0) begin
         errors++;
         $display("FAIL first load pulse width: got %b expected 0", bus.o_inc_valid);
      end
      coarse_m = 0;
      fine_m   = 0;
   endtask

   task automatic test_single_press;
      int unsigned v0;
      v0 = vcount;
      bus.i_aumentar = 1'b1;
      tick(6);
      bus.i_aumentar = 1'b0;
      tick(2);
      checks++;
      if (bus.o_incremento !== 32'h0000_8638 || bus.o_inc_valid !== 1'b0) begin
         errors++;
         $display("FAIL press early: got %h %b expected 00008638 0", bus.o_incremento, bus.o_inc_valid);
      end
      tick();
      checks++;
      if (bus.o_incremento !== 32'h0000_C898 || bus.o_inc_valid !== 1'b1 || bus.o_leds_grueso !== 4'd1) begin
         errors++;
         $display("FAIL press latency: got %h %b %0d expected 0000c898 1 1",
                  bus.o_incremento, bus.o_inc_valid, bus.o_leds_grueso);
      end
      tick(12);
      checks++;
      if (vcount - v0 != 1) begin
         errors++;
         $display("FAIL press pulses: got %0d expected 1", vcount - v0);
      end
      coarse_m = 1;
   endtask

   task automatic test_hold_repeat;
      do_press(0, 100, "hold_up");
      checks++;
      if (bus.o_incremento !== 32'h020A_1F1A) begin
         errors++;
         $display("FAIL top saturation word: got %h expected 020a1f1a", bus.o_incremento);
      end
   endtask

   task automatic test_both;
      do_press(2, 200, "both");
   endtask

   task automatic test_fine;
      do_press(1, 200, "hold_down");
      do_press(0, 6, "to_coarse1");
      set_mode(1'b1);
      do_press(1, 60, "fine_zero");
      for (int i = 0; i < 3; i++) do_press(0, 6, "fine_up");
      checks++;
      if (bus.o_incremento !== 32'h0000_CB98) begin
         errors++;
         $display("FAIL fine +3 word: got %h expected 0000cb98", bus.o_incremento);
      end
      for (int i = 0; i < 5; i++) do_press(1, 6, "fine_down");
      checks++;
      if (bus.o_incremento !== 32'h0000_C898 || bus.o_leds_fino !== 3'd0) begin
         errors++;
         $display("FAIL fine bottom: got %h %0d expected 0000c898 0", bus.o_incremento, bus.o_leds_fino);
      end
      do_press(0, 100, "fine_top");
   endtask

   task automatic test_word_saturate;
      set_mode(1'b0);
      do_press(0, 100, "sat_up");
      do_press(1, 6, "sat_to14");
      checks++;
      if (bus.o_incremento !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL word saturation: got %h expected ffffffff", bus.o_incremento);
      end
   endtask

   task automatic test_random;
      logic m;
      int   btn;
      for (int i = 0; i < 16; i++) begin
         m = 1'($urandom_range(0, 1));
         if (m != mode_m) set_mode(m);
         btn = int'($urandom_range(0, 2));
         do_press(btn, $urandom_range(1, 45), "random");
      end
   endtask

   task automatic test_sweep;
      int unsigned idx, prev;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      checks++;
      if (bus.o_sweeping !== 1'b1 || bus.o_leds_grueso !== 4'd0) begin
         errors++;
         $display("FAIL sweep entry: got %b %0d expected 1 0", bus.o_sweeping, bus.o_leds_grueso);
      end
      for (int j = 1; j <= 169; j++) begin
         if (j == 10) bus.i_aumentar = 1'b1;
         if (j == 20) bus.i_aumentar = 1'b0;
         tick();
         idx  = (j / DWELL) % DEPTH;
         prev = ((j - 1) / DWELL) % DEPTH;
         checks++;
         if (bus.o_leds_grueso !== 4'(idx) || bus.o_incremento !== word_m(prev, fine_m)) begin
            errors++;
            $display("FAIL sweep step %0d: got %0d %h expected %0d %h",
                     j, bus.o_leds_grueso, bus.o_incremento, idx, word_m(prev, fine_m));
         end
      end
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      checks++;
      if (bus.o_sweeping !== 1'b0 || bus.o_leds_grueso !== 4'd5) begin
         errors++;
         $display("FAIL sweep exit: got %b %0d expected 0 5", bus.o_sweeping, bus.o_leds_grueso);
      end
      tick(3);
      coarse_m = 5;
      checks++;
      if (bus.o_leds_grueso !== 4'd5 || bus.o_incremento !== word_m(5, fine_m) || bus.o_leds_fino !== 3'(fine_m)) begin
         errors++;
         $display("FAIL sweep hold: got %0d %0d %h expected 5 %0d %h",
                  bus.o_leds_grueso, bus.o_leds_fino, bus.o_incremento, fine_m, word_m(5, fine_m));
      end
   endtask

   task automatic test_reset_mid_sweep;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      tick(72);
      checks++;
      if (bus.o_sweeping !== 1'b1 || bus.o_leds_grueso !== 4'd9) begin
         errors++;
         $display("FAIL pre-reset sweep: got %b %0d expected 1 9", bus.o_sweeping, bus.o_leds_grueso);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (bus.o_sweeping !== 1'b0 || bus.o_leds_grueso !== 4'd0 || bus.o_leds_fino !== 3'd0 ||
          bus.o_incremento !== 32'd0 || bus.o_inc_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid-sweep reset: got %b %0d %0d %h %b expected 0 0 0 0 0", bus.o_sweeping,
                  bus.o_leds_grueso, bus.o_leds_fino, bus.o_incremento, bus.o_inc_valid);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.o_incremento !== tbl[0] || bus.o_inc_valid !== 1'b1) begin
         errors++;
         $display("FAIL reload after reset: got %h %b expected %h 1", bus.o_incremento, bus.o_inc_valid, tbl[0]);
      end
      coarse_m = 0;
      fine_m   = 0;
   endtask

   task automatic test_freeze;
      int unsigned v0;
      set_mode(1'b0);
      v0 = vcount;
      bus.i_aumentar = 1'b1;
      tick(3);
      en = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         checks++;
         if (bus.o_incremento !== word_m(coarse_m, fine_m) || bus.o_inc_valid !== 1'b0 ||
             bus.o_leds_grueso !== 4'(coarse_m)) begin
            errors++;
            $display("FAIL freeze cycle %0d: got %h %b %0d expected %h 0 %0d", i, bus.o_incremento,
                     bus.o_inc_valid, bus.o_leds_grueso, word_m(coarse_m, fine_m), coarse_m);
         end
      end
      en = 1'b1;
      tick(3);
      bus.i_aumentar = 1'b0;
      tick(12);
      coarse_m += n_events(6);
      checks++;
      if (bus.o_leds_grueso !== 4'(coarse_m) || bus.o_incremento !== word_m(coarse_m, fine_m)) begin
         errors++;
         $display("FAIL after freeze: got %0d %h expected %0d %h", bus.o_leds_grueso,
                  bus.o_incremento, coarse_m, word_m(coarse_m, fine_m));
      end
      checks++;
      if (vcount - v0 != 1) begin
         errors++;
         $display("FAIL freeze pulses: got %0d expected 1", vcount - v0);
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      mode_m = 1'b0;
      bus.i_start       = 1'b0;
      bus.i_aumentar    = 1'b0;
      bus.i_disminuir   = 1'b0;
      bus.i_tipo_ajuste = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) tbl[i] = $urandom;
      tbl[0]  = 32'h0000_8638;
      tbl[1]  = 32'h0000_C898;
      tbl[2]  = 32'h0001_2B1C;
      tbl[14] = 32'hFFFF_FF80;
      tbl[15] = 32'h020A_1F1A;
      for (int i = 0; i < int'(DEPTH); i++) bus.i_rom_incremento_grueso[i] = tbl[i];

      test_reset();
      test_single_press();
      test_hold_repeat();
      test_both();
      test_fine();
      test_word_saturate();
      test_random();
      test_sweep();
      test_reset_mid_sweep();
      test_freeze();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
